// File: rtl/sfp_pkg.sv
// sfp_pkg: shared constants and types for the standard-float / self-float
// converters.
//   - flag bit positions inside the 3-bit {nan, ovf, uf} flag vector
//   - IEEE-754 single field constants
//   - input classification type
//   - self-format exponent bias helper
package sfp_pkg;

   localparam int FLG_NAN = 2;
   localparam int FLG_OVF = 1;
   localparam int FLG_UF  = 0;

   localparam int SGL_BIAS    = 127;
   localparam int SGL_EXP_MAX = 255;
   localparam int SGL_FW      = 23;

   typedef enum logic [2:0] {
      CLS_NORM = 3'd0,
      CLS_ZERO = 3'd1,
      CLS_DEN  = 3'd2,
      CLS_INF  = 3'd3,
      CLS_NAN  = 3'd4
   } cls_t;

   // Self-format exponent bias for an exponent field of ew bits.
   function automatic int slf_bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

endpackage

// File: rtl/sfp_rnd.sv
// sfp_rnd: combinational fraction round unit.
// Ports:
//   frac      in   FW  kept fraction bits (no hidden bit)
//   grs       in   3   guard, round, sticky of the dropped bits
//   rne       in   1   1 = round-nearest-even, 0 = truncate
//   frac_rnd  out  FW  rounded fraction (all zero on carry-out)
//   carry     out  1   rounding overflowed out of the fraction
module sfp_rnd
   import sfp_pkg::*;
#(
   parameter int FW = 17
)(
   input  logic [FW-1:0] frac,
   input  logic [2:0]    grs,
   input  logic          rne,
   output logic [FW-1:0] frac_rnd,
   output logic          carry
);

   logic          inc;
   logic [FW:0]   sum;

   // Increment above half, or on an exact half when the kept LSB is odd.
   always_comb begin
      inc      = rne & grs[2] & (grs[1] | grs[0] | frac[0]);
      sum      = {1'b0, frac} + {{FW{1'b0}}, inc};
      frac_rnd = sum[FW-1:0];
      carry    = sum[FW];
   end

endmodule

// File: rtl/sfp_std2slf_pipe.sv
// sfp_std2slf_pipe: three-stage IEEE-754 single to self-float converter with
// valid/ready backpressure, exception flags and saturating flag counters.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req / o_rdy         input handshake (o_rdy = global advance enable)
//   i_dat, i_rnd          single-precision word and its rounding mode
//   o_vld / i_rdy         output handshake
//   o_dat, o_flg          self-float {sign, exp, frac} and {nan, ovf, uf}
//   i_clr                 synchronous clear of both counters
//   o_cnt_ovf, o_cnt_uf   saturating counts of delivered ovf / uf words
module sfp_std2slf_pipe
   import sfp_pkg::*;
#(
   parameter int EW = 8,
   parameter int MW = 17,
   parameter int CW = 16
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req,
   output logic             o_rdy,
   input  logic [31:0]      i_dat,
   input  logic             i_rnd,
   output logic             o_vld,
   input  logic             i_rdy,
   output logic [EW+MW:0]   o_dat,
   output logic [2:0]       o_flg,
   input  logic             i_clr,
   output logic [CW-1:0]    o_cnt_ovf,
   output logic [CW-1:0]    o_cnt_uf
);

   localparam int OW = 1 + EW + MW;
   // Wide enough to hold the full single exponent range even for small EW.
   localparam int TW = (EW + 3 < 10) ? 10 : EW + 3;
   localparam int DW = (MW < SGL_FW) ? SGL_FW - MW : 0;

   localparam logic signed [TW-1:0] T_BIAS = TW'(slf_bias(EW) - SGL_BIAS);
   localparam logic signed [TW-1:0] T_MAX  = TW'((1 << EW) - 1);
   localparam logic signed [TW-1:0] T_ZERO = '0;

   logic en;
   assign en    = ~o_vld | i_rdy;
   assign o_rdy = en;

   // Input decode
   logic                  sgn_in;
   logic [7:0]            exp_in;
   logic [SGL_FW-1:0]     frc_in;
   cls_t                  cls_in;
   logic signed [TW-1:0]  t_in;
   logic [MW-1:0]         kept_in;
   logic [2:0]            grs_in;

   assign sgn_in = i_dat[31];
   assign exp_in = i_dat[30:23];
   assign frc_in = i_dat[22:0];

   always_comb begin
      if (exp_in == 8'(SGL_EXP_MAX))
         cls_in = (frc_in != '0) ? CLS_NAN : CLS_INF;
      else if (exp_in == 8'd0)
         cls_in = (frc_in != '0) ? CLS_DEN : CLS_ZERO;
      else
         cls_in = CLS_NORM;
      t_in = $signed({{(TW-8){1'b0}}, exp_in}) + T_BIAS;
   end

   generate
      if (DW == 0) begin : g_pad
         always_comb begin
            kept_in = '0;
            kept_in[MW-1 -: SGL_FW] = frc_in;
            grs_in  = 3'b000;
         end
      end else begin : g_drop
         // Two zero bits appended so a single dropped bit still yields g/r/s.
         logic [DW+1:0] drop_ext;
         always_comb begin
            drop_ext = {frc_in[DW-1:0], 2'b00};
            kept_in  = frc_in[SGL_FW-1 -: MW];
            grs_in   = {drop_ext[DW+1], drop_ext[DW], |drop_ext[DW-1:0]};
         end
      end
   endgenerate

   // ---- S1: classify, target exponent, guard/round/sticky ----
   logic                  vld_p0;
   logic                  sgn_p0;
   cls_t                  cls_p0;
   logic signed [TW-1:0]  t_p0;
   logic [MW-1:0]         kept_p0;
   logic [2:0]            grs_p0;
   logic                  rne_p0;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         vld_p0 <= 1'b0;
      else if (en)
         vld_p0 <= i_req;
   end

   always_ff @(posedge i_clk) begin
      if (en) begin
         sgn_p0  <= sgn_in;
         cls_p0  <= cls_in;
         t_p0    <= t_in;
         kept_p0 <= kept_in;
         grs_p0  <= grs_in;
         rne_p0  <= i_rnd;
      end
   end

   // ---- S2: round and carry into the exponent ----
   logic [MW-1:0]         frc_rnd;
   logic                  carry_rnd;

   sfp_rnd #(.FW(MW)) u_rnd (
      .frac     (kept_p0),
      .grs      (grs_p0),
      .rne      (rne_p0),
      .frac_rnd (frc_rnd),
      .carry    (carry_rnd)
   );

   logic                  vld_p1;
   logic                  sgn_p1;
   cls_t                  cls_p1;
   logic signed [TW-1:0]  t_p1;
   logic [MW-1:0]         frc_p1;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         vld_p1 <= 1'b0;
      else if (en)
         vld_p1 <= vld_p0;
   end

   always_ff @(posedge i_clk) begin
      if (en) begin
         sgn_p1 <= sgn_p0;
         cls_p1 <= cls_p0;
         t_p1   <= t_p0 + $signed({{(TW-1){1'b0}}, carry_rnd});
         frc_p1 <= frc_rnd;
      end
   end

   // ---- S3: pack, saturate, flag ----
   logic [OW-1:0] dat_nx;
   logic [2:0]    flg_nx;

   always_comb begin
      dat_nx         = '0;
      flg_nx         = '0;
      dat_nx[OW-1]   = sgn_p1;
      case (cls_p1)
         CLS_NAN: begin
            dat_nx[OW-2 -: EW] = '1;
            dat_nx[MW-1]       = 1'b1;
            flg_nx[FLG_NAN]    = 1'b1;
         end
         CLS_INF: begin
            dat_nx[OW-2 -: EW] = '1;
         end
         CLS_DEN: begin
            flg_nx[FLG_UF] = 1'b1;
         end
         CLS_ZERO: begin
            flg_nx = '0;
         end
         default: begin
            if (t_p1 >= T_MAX) begin
               dat_nx[OW-2 -: EW] = '1;
               flg_nx[FLG_OVF]    = 1'b1;
            end else if (t_p1 <= T_ZERO) begin
               flg_nx[FLG_UF] = 1'b1;
            end else begin
               dat_nx[OW-2 -: EW] = t_p1[EW-1:0];
               dat_nx[MW-1:0]     = frc_p1;
            end
         end
      endcase
   end

   // Output data only loads on a real word so bubbles and stale stage
   // contents never disturb o_dat/o_flg.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_vld <= 1'b0;
         o_dat <= '0;
         o_flg <= '0;
      end else if (en) begin
         o_vld <= vld_p1;
         if (vld_p1) begin
            o_dat <= dat_nx;
            o_flg <= flg_nx;
         end
      end
   end

   // Flag counters: count delivered words, saturate, clear wins.
   logic deliver;
   assign deliver = o_vld & i_rdy;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         o_cnt_ovf <= '0;
      else if (deliver && o_flg[FLG_OVF] && !(&o_cnt_ovf))
         o_cnt_ovf <= o_cnt_ovf + CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         o_cnt_uf <= '0;
      else if (deliver && o_flg[FLG_UF] && !(&o_cnt_uf))
         o_cnt_uf <= o_cnt_uf + CW'(1);
   end

endmodule

// File: tb/tb_sfp_std2slf_pipe.sv
// tb_sfp_std2slf_pipe: directed and short random checks of sfp_std2slf_pipe.
// Instance A uses the default EW=8, MW=17, CW=16; instance B uses EW=5,
// MW=10 with a 4-bit counter so saturation is reachable quickly.
`timescale 1ns/1ps
module tb_sfp_std2slf_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // instance A
   logic        req_a, ordy_a, rnd_a, vld_a, rdy_a, clr_a;
   logic [31:0] dat_a;
   logic [25:0] odat_a;
   logic [2:0]  flg_a;
   logic [15:0] cov_a, cuf_a;

   // instance B
   logic        req_b, ordy_b, rnd_b, vld_b, rdy_b, clr_b;
   logic [31:0] dat_b;
   logic [15:0] odat_b;
   logic [2:0]  flg_b;
   logic [3:0]  cov_b, cuf_b;

   sfp_std2slf_pipe #(.EW(8), .MW(17), .CW(16)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_req(req_a), .o_rdy(ordy_a),
      .i_dat(dat_a), .i_rnd(rnd_a), .o_vld(vld_a), .i_rdy(rdy_a),
      .o_dat(odat_a), .o_flg(flg_a), .i_clr(clr_a),
      .o_cnt_ovf(cov_a), .o_cnt_uf(cuf_a)
   );

   sfp_std2slf_pipe #(.EW(5), .MW(10), .CW(4)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_req(req_b), .o_rdy(ordy_b),
      .i_dat(dat_b), .i_rnd(rnd_b), .o_vld(vld_b), .i_rdy(rdy_b),
      .o_dat(odat_b), .o_flg(flg_b), .i_clr(clr_b),
      .o_cnt_ovf(cov_b), .o_cnt_uf(cuf_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [25:0] d;
      logic [2:0]  f;
   } exp_t;

   exp_t q_a[$];
   exp_t mon_e;
   bit   mon_en = 1'b1;

   // Output monitor for A: every delivered word is compared in order.
   always @(negedge clk) begin
      if (mon_en && !rst && vld_a && rdy_a) begin
         if (q_a.size() == 0) begin
            check_eq("a_unexpected_word", 64'(odat_a), 64'h3FFFFFFFF);
         end else begin
            mon_e = q_a.pop_front();
            check_eq("a_dat", 64'(odat_a), 64'(mon_e.d));
            check_eq("a_flg", 64'(flg_a), 64'(mon_e.f));
         end
      end
   end

   // Reference for EW=8, MW=17 using 24-bit hidden-bit mantissa arithmetic.
   function automatic void model_a(input logic [31:0] d, input logic r,
                                   output logic [25:0] od, output logic [2:0] of);
      logic s;
      int   e, m, q, rem;
      s  = d[31];
      e  = int'(d[30:23]);
      of = 3'b000;
      if (e == 255) begin
         if (d[22:0] != 0) begin
            od = {s, 8'hFF, 17'h10000};
            of = 3'b100;
         end else begin
            od = {s, 8'hFF, 17'h0};
         end
      end else if (e == 0) begin
         od = {s, 25'h0};
         if (d[22:0] != 0) of = 3'b001;
      end else begin
         m   = int'({1'b1, d[22:0]});
         q   = m >> 6;
         rem = m & 63;
         if (r && (rem > 32 || (rem == 32 && (q & 1) == 1))) q = q + 1;
         if (q == (1 << 18)) begin
            q = 1 << 17;
            e = e + 1;
         end
         if (e >= 255) begin
            od = {s, 8'hFF, 17'h0};
            of = 3'b010;
         end else begin
            od = {s, e[7:0], q[16:0]};
         end
      end
   endfunction

   // Offer a word to A until accepted; queue its expected result.
   task automatic send_a(input logic [31:0] d, input logic r,
                         input logic [25:0] ed, input logic [2:0] ef);
      bit   acc;
      int   guard;
      exp_t e;
      req_a = 1'b1; dat_a = d; rnd_a = r;
      acc = 1'b0; guard = 0;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = ordy_a;
         @(posedge clk);
         guard++;
      end
      #1 req_a = 1'b0;
      if (!acc) begin
         check_eq("a_accept_timeout", 64'd0, 64'd1);
      end else begin
         e.d = ed; e.f = ef;
         q_a.push_back(e);
      end
   endtask

   // Called right after an accept: o_vld must appear on the third cycle.
   task automatic latency_a(input string tag);
      @(negedge clk); check_eq({tag, "_c1"}, 64'(vld_a), 64'd0);
      @(negedge clk); check_eq({tag, "_c2"}, 64'(vld_a), 64'd0);
      @(negedge clk); check_eq({tag, "_c3"}, 64'(vld_a), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic drain_a(input string tag);
      int n;
      n = 0;
      while (q_a.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      check_eq(tag, 64'(q_a.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Hold i_rdy low for n cycles while A has a word waiting.
   task automatic stall_a(input int n);
      logic [25:0] held;
      @(posedge clk); #1 rdy_a = 1'b0;
      @(negedge clk);
      held = odat_a;
      for (int i = 0; i < n; i++) begin
         check_eq("a_stall_vld", 64'(vld_a), 64'd1);
         check_eq("a_stall_ordy", 64'(ordy_a), 64'd0);
         if (i > 0) check_eq("a_stall_hold", 64'(odat_a), 64'(held));
         if (i < n - 1) @(negedge clk);
      end
      @(posedge clk); #1 rdy_a = 1'b1;
   endtask

   task automatic send_b(input logic [31:0] d);
      bit acc;
      int guard;
      req_b = 1'b1; dat_b = d; rnd_b = 1'b1;
      acc = 1'b0; guard = 0;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = ordy_b;
         @(posedge clk);
         guard++;
      end
      #1 req_b = 1'b0;
      if (!acc) check_eq("b_accept_timeout", 64'd0, 64'd1);
   endtask

   // Returns at the negedge where B presents a word.
   task automatic wait_b(input string tag);
      bit seen;
      int n;
      seen = 1'b0; n = 0;
      while (!seen && n < 10) begin
         @(negedge clk);
         seen = vld_b;
         n++;
      end
      check_eq(tag, 64'(seen), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit seen_vld;
      rst = 1'b1;
      req_a = 1'b0; dat_a = '0; rnd_a = 1'b1; rdy_a = 1'b1; clr_a = 1'b0;
      req_b = 1'b0; dat_b = '0; rnd_b = 1'b1; rdy_b = 1'b1; clr_b = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      check_eq("rst_vld_a", 64'(vld_a), 64'd0);
      check_eq("rst_dat_a", 64'(odat_a), 64'd0);
      check_eq("rst_flg_a", 64'(flg_a), 64'd0);
      check_eq("rst_cov_a", 64'(cov_a), 64'd0);
      check_eq("rst_cuf_a", 64'(cuf_a), 64'd0);
      check_eq("rst_ordy_a", 64'(ordy_a), 64'd1);
      check_eq("rst_vld_b", 64'(vld_b), 64'd0);
      check_eq("rst_dat_b", 64'(odat_b), 64'd0);
      @(posedge clk); #1;

      // first word with latency probe
      send_a(32'h3F800000, 1'b1, 26'h0FE0000, 3'b000);
      latency_a("a_lat");

      // directed vectors, back to back
      send_a(32'h3F80003F, 1'b1, 26'h0FE0001, 3'b000);
      send_a(32'h3F800020, 1'b1, 26'h0FE0000, 3'b000);
      send_a(32'h3F800060, 1'b1, 26'h0FE0002, 3'b000);
      send_a(32'h3FFFFFFF, 1'b1, 26'h1000000, 3'b000);
      send_a(32'h3FFFFFFF, 1'b0, 26'h0FFFFFF, 3'b000);
      send_a(32'h7FC00001, 1'b1, 26'h1FF0000, 3'b100);
      send_a(32'hFF800000, 1'b1, 26'h3FE0000, 3'b000);
      send_a(32'h00000001, 1'b1, 26'h0000000, 3'b001);
      send_a(32'h80000000, 1'b1, 26'h2000000, 3'b000);
      send_a(32'h7F7FFFFF, 1'b1, 26'h1FE0000, 3'b010);
      send_a(32'h7F7FFFFF, 1'b0, 26'h1FDFFFF, 3'b000);
      drain_a("a_drain_directed");
      check_eq("a_cnt_uf", 64'(cuf_a), 64'd1);
      check_eq("a_cnt_ovf", 64'(cov_a), 64'd1);

      // reset with three words in flight
      mon_en = 1'b0;
      send_a(32'h40000000, 1'b1, 26'h1000000, 3'b000);
      send_a(32'h00000002, 1'b1, 26'h0000000, 3'b001);
      send_a(32'h40400000, 1'b1, 26'h1010000, 3'b000);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q_a.delete();
      mon_en = 1'b1;
      seen_vld = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (vld_a) seen_vld = 1'b1;
      end
      check_eq("a_rst_no_vld", 64'(seen_vld), 64'd0);
      check_eq("a_rst_dat", 64'(odat_a), 64'd0);
      check_eq("a_rst_flg", 64'(flg_a), 64'd0);
      check_eq("a_rst_cuf", 64'(cuf_a), 64'd0);
      check_eq("a_rst_cov", 64'(cov_a), 64'd0);
      check_eq("a_rst_ordy", 64'(ordy_a), 64'd1);
      @(posedge clk); #1;
      send_a(32'h40000000, 1'b1, 26'h1000000, 3'b000);
      latency_a("a_lat_post_rst");
      drain_a("a_drain_post_rst");

      // random back-to-back stream with a 5-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [31:0] w;
               logic        r;
               logic [25:0] ed;
               logic [2:0]  ef;
               w = $urandom;
               r = 1'($urandom_range(0, 1));
               model_a(w, r, ed, ef);
               send_a(w, r, ed, ef);
            end
         end
         begin
            repeat (10) @(posedge clk);
            stall_a(5);
         end
      join
      drain_a("a_drain_random");

      // instance B: EW=5, MW=10, CW=4
      send_b(32'h49742400);
      wait_b("b_ovf_vld");
      check_eq("b_ovf_dat", 64'(odat_b), 64'h7C00);
      check_eq("b_ovf_flg", 64'(flg_b), 64'd2);
      @(posedge clk); #1;
      check_eq("b_cnt_ovf_1", 64'(cov_b), 64'd1);

      send_b(32'h3F800000);
      wait_b("b_one_vld");
      check_eq("b_one_dat", 64'(odat_b), 64'h3C00);
      check_eq("b_one_flg", 64'(flg_b), 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++) send_b(32'h49742400);
      repeat (6) @(posedge clk);
      #1;
      check_eq("b_cnt_ovf_sat", 64'(cov_b), 64'hF);

      send_b(32'hC9742400);
      wait_b("b_clr_vld");
      check_eq("b_clr_flg", 64'(flg_b), 64'd2);
      clr_b = 1'b1;
      @(posedge clk); #1;
      clr_b = 1'b0;
      check_eq("b_cnt_ovf_clr", 64'(cov_b), 64'd0);
      check_eq("b_clr_delivered", 64'(vld_b), 64'd0);
      check_eq("b_cnt_uf", 64'(cuf_b), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
